// File: rtl/regfile_pkg.sv
// Shared sizing for the 32 x 64-bit register file storage core.
package regfile_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned WIDTH     = 64;
  localparam int unsigned ZERO_REG  = 31;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/decoder5_32.sv
// 5:32 write-index decoder; output is one-hot when en=1, all-zero otherwise.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] idx,
  output logic [NUM_REGS-1:0]  dec
);

  // Gating by en keeps an unknown idx from producing stray enables.
  always_comb begin
    dec = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      dec[i] = en & (idx == REG_IDX_W'(i));
    end
  end

endmodule

// File: rtl/reg64_en.sv
// 64-bit register with load enable and asynchronous active-high clear.
module reg64_en
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  word_t d,
  output word_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= en ? d : q;
    end
  end

endmodule

// File: rtl/reg_array_32x64.sv
// Register file storage: 31 writable 64-bit registers plus hardwired-zero X31,
// exposed as one packed bus for the downstream read multiplexers.
module reg_array_32x64
  import regfile_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            RegWrite,
  input  logic [REG_IDX_W-1:0]            WriteRegister,
  input  logic [WIDTH-1:0]                WriteData,
  output logic [NUM_REGS-1:0][WIDTH-1:0]  regs
);

  logic [NUM_REGS-1:0] dec_en;
  word_t               q [NUM_REGS];
  logic                unused_zero_en;

  decoder5_32 u_dec (
    .en  (RegWrite),
    .idx (WriteRegister),
    .dec (dec_en)
  );

  // The zero register has no storage, so its decoded enable goes nowhere.
  assign unused_zero_en = dec_en[ZERO_REG];

  genvar i;
  generate
    for (i = 0; i < int'(NUM_REGS); i++) begin : g_reg
      if (i == int'(ZERO_REG)) begin : g_zero
        assign q[i] = '0;
      end else begin : g_store
        reg64_en u_reg (
          .clk   (clk),
          .reset (reset),
          .en    (dec_en[i]),
          .d     (WriteData),
          .q     (q[i])
        );
      end
    end
  endgenerate

  always_comb begin
    regs = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      regs[k] = q[k];
    end
  end

endmodule

// File: tb/tb_reg_array_32x64.sv
// Scoreboard bench for reg_array_32x64: expected register snapshots are queued
// on each drive and compared after the clock edge.
module tb_reg_array_32x64;
  import regfile_pkg::*;

  logic                           clk;
  logic                           reset;
  logic                           RegWrite;
  logic [REG_IDX_W-1:0]           WriteRegister;
  logic [WIDTH-1:0]               WriteData;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [32];
  int          n_checks;
  int          n_fail;
  string       cur_tag;

  reg_array_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  task automatic push_all();
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      e.idx = 5'(i);
      e.val = model[i];
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("%s r%0d", cur_tag, e.idx), regs[e.idx], e.val);
    end
  endtask

  // Drive one write-port cycle; old value must still be visible before the edge.
  task automatic do_write(input logic we, input logic [4:0] idx, input logic [63:0] data,
                          input string tag);
    @(negedge clk);
    RegWrite      = we;
    WriteRegister = idx;
    WriteData     = data;
    cur_tag       = tag;
    #1;
    if (we) check({tag, " pre-edge"}, regs[idx], model[idx]);
    if (we && idx != 5'd31) model[idx] = data;
    push_all();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'h0;
    cur_tag       = "reset";
    model_clear();

    // Reset before any clock edge.
    #1;
    push_all();
    drain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_write(1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, "wr5");
    do_write(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, "wr31");
    do_write(1'b0, 5'd7,  64'h1234, "nowe7");
    do_write(1'b0, 5'bxxxxx, 64'hFFFF_FFFF_FFFF_FFFF, "nowe_x");
    do_write(1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, "overwr5");

    for (int i = 0; i <= 30; i++) begin
      do_write(1'b1, 5'(i), {32'hA5A5_0000 + 32'(i), 32'(i)}, $sformatf("loop%0d", i));
    end
    do_write(1'b1, 5'd31, 64'h5555_AAAA_5555_AAAA, "wr31_full");

    // Reset pulsed between edges clears everything without a clock.
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    reset = 1'b1;
    model_clear();
    cur_tag = "midreset";
    #1;
    push_all();
    drain();
    reset = 1'b0;

    do_write(1'b1, 5'd10, 64'hFACE_0000_0000_0010, "prefill10");

    // Reset rising on the same edge as a write: reset wins.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd10;
    WriteData     = 64'h1;
    @(posedge clk);
    reset = 1'b1;
    model_clear();
    cur_tag = "edgereset";
    push_all();
    #1;
    drain();
    @(negedge clk);
    RegWrite = 1'b0;
    reset    = 1'b0;

    do_write(1'b1, 5'd10, 64'h1, "postreset10");
    do_write(1'b1, 5'd0,  64'h8000_0000_0000_0001, "wr0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
